// File: rtl/bcd_pkg.sv
// Shared types and constants for the ten's-complement BCD converter.
// Digit 3 of a 4-digit ten's-complement word encodes the sign (0-4 pos, 5-9 neg).
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FIX
    } state_t;

    localparam int          NDIG        = 4;
    localparam int          TC_MAX_POS  = 4999;
    localparam int          TC_MIN_NEG  = -5000;
    localparam logic [3:0]  NEG_MSD_MIN = 4'd5;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit adjust: a digit of 5 or more gets +3 before the shift.
module bcd_add3 (
    input  logic [3:0] i_d,
    output logic [3:0] o_d
);

    assign o_d = (i_d >= 4'd5) ? i_d + 4'd3 : i_d;

endmodule

// File: rtl/bin_to_tenscomp_bcd.sv
// Signed binary to 4-digit ten's-complement BCD, double-dabble core
// followed by a single nine's-complement-plus-one fix-up cycle.
module bin_to_tenscomp_bcd
    import bcd_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         start,
    input  logic [W-1:0] din,
    output logic         busy,
    output logic         done,
    output logic [15:0]  dout,
    output logic         ovunflow
);

    localparam int CW = $clog2(W + 1);

    state_t             r_state;
    state_t             w_next;
    logic               r_sign;
    logic               r_err;
    logic [W-1:0]       r_mag;
    logic [15:0]        r_acc;
    logic [CW-1:0]      r_cnt;

    logic               w_accept;
    logic signed [31:0] w_din_s;
    logic [W-1:0]       w_mag;
    logic               w_err;
    logic [15:0]        w_adj;
    logic [15:0]        w_neg;
    logic [15:0]        w_res;

    assign w_din_s = 32'(signed'(din));
    assign w_mag   = din[W-1] ? (~din + W'(1)) : din;
    assign w_err   = (w_din_s > TC_MAX_POS) || (w_din_s < TC_MIN_NEG);

    // FIX edge doubles as an accept edge so throughput is one result per W+1
    assign w_accept = start && (r_state == IDLE || r_state == FIX);
    assign busy     = (r_state != IDLE);

    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        bcd_add3 u_add3 (
            .i_d (r_acc[4*g +: 4]),
            .o_d (w_adj[4*g +: 4])
        );
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = SHIFT;
            SHIFT:   if (r_cnt == CW'(1)) w_next = FIX;
            FIX:     w_next = start ? SHIFT : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin : fixup
        logic       c;
        logic [4:0] s;
        c     = 1'b1;
        s     = '0;
        w_neg = '0;
        for (int i = 0; i < NDIG; i++) begin
            s = {1'b0, 4'd9 - r_acc[4*i +: 4]} + {4'd0, c};
            if (s == 5'd10) begin
                w_neg[4*i +: 4] = 4'd0;
                c = 1'b1;
            end else begin
                w_neg[4*i +: 4] = s[3:0];
                c = 1'b0;
            end
        end
    end

    always_comb begin
        w_res = r_acc;
        if (r_err) begin
            w_res = '0;
        end else if (r_sign && r_acc != '0) begin
            w_res = w_neg;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_sign   <= 1'b0;
            r_err    <= 1'b0;
            r_mag    <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            done     <= 1'b0;
            dout     <= '0;
            ovunflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_accept) begin
                r_sign <= din[W-1];
                r_mag  <= w_mag;
                r_err  <= w_err;
                r_acc  <= '0;
                r_cnt  <= CW'(W);
            end else if (r_state == SHIFT) begin
                r_acc  <= {w_adj[14:0], r_mag[W-1]};
                r_mag  <= {r_mag[W-2:0], 1'b0};
                r_cnt  <= r_cnt - CW'(1);
            end
            if (r_state == FIX) begin
                if (r_sign && !r_err && r_acc != '0) begin
                    assert (w_neg[15:12] >= NEG_MSD_MIN);
                end
                dout     <= w_res;
                ovunflow <= r_err;
                done     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bin_to_tenscomp_bcd.sv
// Self-checking bench: directed cases plus a randomized sweep against
// an arithmetic reference model of ten's-complement BCD encoding.
module tb_bin_to_tenscomp_bcd;

    localparam int W   = 16;
    localparam int LAT = W + 1;

    logic        clk;
    logic        clr_n;
    logic        start;
    logic [15:0] din;
    logic        busy;
    logic        done;
    logic [15:0] dout;
    logic        ovunflow;

    int n_cmp;
    int n_bad;

    bin_to_tenscomp_bcd #(.W(W)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .start    (start),
        .din      (din),
        .busy     (busy),
        .done     (done),
        .dout     (dout),
        .ovunflow (ovunflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model(input int v, output logic [15:0] d,
                                  output logic o);
        int n;
        if (v > 4999 || v < -5000) begin
            d = 16'h0000;
            o = 1'b1;
        end else begin
            n = (v < 0) ? 10000 + v : v;
            d = {4'(n / 1000 % 10), 4'(n / 100 % 10),
                 4'(n / 10 % 10), 4'(n % 10)};
            o = 1'b0;
        end
    endfunction

    // Pulses start for one cycle, then waits for done; k counts edges after accept.
    task automatic run_conv(input logic [15:0] v, output int lat,
                            output int busy_bad);
        int k;
        @(negedge clk);
        din   = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        busy_bad = 0;
        while (!done && k < 40) begin
            if (busy !== 1'b1) busy_bad++;
            @(negedge clk);
            k++;
        end
        lat = done ? k : -1;
    endtask

    task automatic check_conv(input string nm, input logic [15:0] v);
        int          lat;
        int          bb;
        logic [15:0] ed;
        logic        eo;
        model(int'($signed(v)), ed, eo);
        run_conv(v, lat, bb);
        n_cmp++;
        if (lat != LAT) begin
            n_bad++;
            $display("FAIL %s latency: got %0d want %0d", nm, lat, LAT);
        end
        n_cmp++;
        if (dout !== ed || ovunflow !== eo) begin
            n_bad++;
            $display("FAIL %s din=%0d: got dout=%h ovf=%b want dout=%h ovf=%b",
                     nm, $signed(v), dout, ovunflow, ed, eo);
        end
        n_cmp++;
        if (bb != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s busy: %0d low samples, busy at done=%b want 0",
                     nm, bb, busy);
        end
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        start = 1'b0;
        din   = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, dout, ovunflow} !== 19'd0) begin
            n_bad++;
            $display("FAIL reset: got busy=%b done=%b dout=%h ovf=%b want all 0",
                     busy, done, dout, ovunflow);
        end
        clr_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        check_conv("basic_1234", 16'd1234);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL done_width: got done=%b want 0", done);
        end
    endtask

    task automatic test_negative();
        check_conv("neg_minus1", 16'hFFFF);
        check_conv("neg_minus5000", 16'(-5000));
        check_conv("zero", 16'h0000);
    endtask

    task automatic test_range();
        check_conv("pos_4999", 16'd4999);
        check_conv("pos_5000", 16'd5000);
        check_conv("min_8000", 16'h8000);
        check_conv("neg_5001", 16'(-5001));
        check_conv("max_7fff", 16'h7FFF);
    endtask

    task automatic test_ignore_start();
        int          k;
        int          ndone;
        int          kdone;
        logic [15:0] sd;
        @(negedge clk);
        din   = 16'd1234;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        kdone = -1;
        sd    = '0;
        for (k = 0; k < 45; k++) begin
            if (k == 5) begin
                din   = 16'd777;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                kdone = k;
                sd = dout;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (ndone != 1 || kdone != LAT || sd !== 16'h1234) begin
            n_bad++;
            $display("FAIL ignore_start: dones=%0d at %0d dout=%h want 1 at %0d 1234",
                     ndone, kdone, sd, LAT);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals[72];
        int          dk[$];
        logic [15:0] dd[$];
        logic        dov[$];
        logic [15:0] ed;
        logic        eo;
        int          src;
        for (int j = 0; j < 72; j++) begin
            vals[j] = 16'($urandom_range(0, 9999) - 5000);
        end
        vals[17] = 16'd9000;
        for (int j = 0; j < 72; j++) begin
            din   = vals[j];
            start = (j <= 51);
            @(negedge clk);
            if (done) begin
                dk.push_back(j);
                dd.push_back(dout);
                dov.push_back(ovunflow);
            end
        end
        start = 1'b0;
        n_cmp++;
        if (dk.size() != 4) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d done pulses want 4", dk.size());
        end
        for (int i = 0; i < dk.size() && i < 4; i++) begin
            src = i * LAT;
            model(int'($signed(vals[src])), ed, eo);
            n_cmp++;
            if (dk[i] != src + LAT || dd[i] !== ed || dov[i] !== eo) begin
                n_bad++;
                $display("FAIL b2b_%0d: done at %0d dout=%h ovf=%b want at %0d dout=%h ovf=%b",
                         i, dk[i], dd[i], dov[i], src + LAT, ed, eo);
            end
        end
    endtask

    task automatic test_abort();
        int ndone;
        @(negedge clk);
        din   = 16'd1234;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        clr_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, dout, ovunflow} !== 19'd0) begin
            n_bad++;
            $display("FAIL abort_outputs: busy=%b done=%b dout=%h ovf=%b want all 0",
                     busy, done, dout, ovunflow);
        end
        @(negedge clk);
        clr_n = 1'b1;
        ndone = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) ndone++;
        end
        n_cmp++;
        if (ndone != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_nodone: dones=%0d busy=%b want 0 0", ndone, busy);
        end
        check_conv("after_abort", 16'd1234);
    endtask

    task automatic test_random_sweep();
        logic [15:0] v;
        for (int i = 0; i < 150; i++) begin
            if (i % 10 == 9) begin
                v = 16'($urandom());
            end else begin
                v = 16'($urandom_range(0, 9999) - 5000);
            end
            check_conv("sweep", v);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clr_n = 1'b0;
        start = 1'b0;
        din   = '0;
        test_reset();
        test_basic();
        test_negative();
        test_range();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        test_random_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
